dkong_wav_out: RTL
==================

// Module: dkong_wav_out
// PURPOSE
//  Downstream stage of the wave-ROM walk/jump/foot address sequencer. Captures the unsigned
//  8-bit ROM byte once per sample strobe and converts it to signed PCM. Applies a
//  click-free gain envelope (instant attack, linear fade) and optionally a one-pole low-pass,
//  then drives a signed 16-bit sample to the sound mixer.
// PARAMETERS
//  SETTLE     2      cycles from I_SMP_STB to ROM byte capture (legal 1..15)
//  FADE_STEP  8'd8   gain decrement per sample strobe while fading (legal 1..255)
//  LPF_SHIFT  2      low-pass coefficient 2^-LPF_SHIFT (legal 0..4; used only with DKONG_WAV_LPF_EN)
// PORTS
//  I_CLK      in   1   system clock
//  I_RST      in   1   reset, synchronous, active-high
//  I_SMP_STB  in   1   one-cycle sample pulse; wave address changes on the same edge
//  I_ACTIVE   in   1   level, high while a wave sound is playing
//  I_ROM_DB   in   8   wave ROM data, unsigned, 8'h80 = silence
//  O_WAV      out  16  signed PCM to mixer
//  O_SMP_VLD  out  1   one-cycle pulse when O_WAV updates
//  O_BUSY     out  1   high in PLAY or FADE
// BEHAVIOUR
//  Reset: O_WAV=0, O_SMP_VLD=0, O_BUSY=0, gain=0, state=IDLE, settle counter cleared, LPF acc=0.
//  Reset mid-sound: everything returns to reset values on the next edge; no fade.
//  Capture pipe (strobe at cycle 0):
//  - Settle counter loads SETTLE. Byte captured at cycle SETTLE: d = I_ROM_DB - 8'h80 (signed 8).
//  - Cycle SETTLE+1: p = d * gain (signed 8 x unsigned 8, 16-bit signed; range -32640..+32385, no overflow).
//  - Cycle SETTLE+2: O_WAV updated, O_SMP_VLD=1 for exactly one cycle.
//  - A strobe arriving while settle count is running restarts the count (latest strobe wins).
//    Only one capture results.
//  FSM (evaluated on each I_CLK):
//  - IDLE: gain=0, O_BUSY=0. I_ACTIVE=1 -> PLAY with gain=8'd255 on the same edge.
//  - PLAY: gain=255. I_ACTIVE=0 -> FADE.
//  - FADE: on each I_SMP_STB, gain = (gain < FADE_STEP) ? 0 : gain - FADE_STEP.
//    - gain reaching 0 -> IDLE.
//    - I_ACTIVE=1 -> PLAY with gain=255 (retrigger wins over a same-cycle strobe decrement).
//  The gain used by the multiply is the value registered at capture time.
//  IDLE still runs the capture pipe (gain 0 -> p=0), so O_WAV settles to 0.
//  O_BUSY = (state != IDLE), registered.
// CONFIGURATION
//  DKONG_WAV_LPF_EN defined:
//  - 18-bit signed acc y, updated at cycle SETTLE+2: y <= y + ((p<<<2 - y) >>> LPF_SHIFT).
//  - O_WAV = y[17:2]. LPF_SHIFT=0 makes O_WAV equal p.
//  DKONG_WAV_LPF_EN undefined: O_WAV = p registered directly; no accumulator is built.
//  Pipe latency, O_SMP_VLD timing and FSM are identical in both builds.
// TESTING
//  1 Reset: I_RST high 3 cycles with random inputs -> O_WAV=0, O_SMP_VLD=0, O_BUSY=0.
//  2 LPF off, I_ACTIVE=1, ROM=8'hFF, strobe at t -> O_SMP_VLD at t+4, O_WAV=16'h7E81.
//    ROM=8'h00 -> 16'h8080. ROM=8'h80 -> 0.
//  3 Fade: ROM=8'hFF, I_ACTIVE falls.
//    - Gain after k strobes = 255-8k; O_WAV after 1st strobe = 127*247 = 16'h7A89.
//    - 32nd strobe -> gain 0, O_BUSY falls, O_WAV=0.
//  4 Retrigger: I_ACTIVE rises during FADE with gain=100, same cycle as a strobe
//    -> gain=255, state PLAY, next O_WAV=127*255.
//  5 Strobe restart: second strobe 1 cycle after first (SETTLE=2)
//    -> single O_SMP_VLD at second strobe +4; byte sampled 2 cycles after second strobe.
//  6 LPF on, LPF_SHIFT=2, step ROM 8'h80->8'hFF at gain 255
//    -> O_WAV per strobe: 8096, 14168, 18722 (each step floor((p<<<2-y)/4)), converges to 32385.

Source files
------------

// File: rtl/dkong_wav_out_if.sv
// rtl/dkong_wav_out_if.sv - sample strobe, ROM byte and PCM output bundle for dkong_wav_out
interface dkong_wav_out_if;
    logic               I_SMP_STB;
    logic               I_ACTIVE;
    logic [7:0]         I_ROM_DB;
    logic signed [15:0] O_WAV;
    logic               O_SMP_VLD;
    logic               O_BUSY;

    modport master (
        output I_SMP_STB, I_ACTIVE, I_ROM_DB,
        input  O_WAV, O_SMP_VLD, O_BUSY
    );

    modport slave (
        input  I_SMP_STB, I_ACTIVE, I_ROM_DB,
        output O_WAV, O_SMP_VLD, O_BUSY
    );
endinterface

// File: rtl/dkong_wav_out.sv
// rtl/dkong_wav_out.sv - wave ROM byte to gain-enveloped signed PCM; DKONG_WAV_LPF_EN adds a one-pole low-pass
module dkong_wav_out #(
    parameter int         SETTLE    = 2,
    parameter logic [7:0] FADE_STEP = 8'd8,
    parameter int         LPF_SHIFT = 2
) (
    input  logic           I_CLK,
    input  logic           I_RST,
    dkong_wav_out_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, FADE = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [7:0]         gain, gain_nxt, gain_dec, gain_cap;
    logic [3:0]         settle_cnt;
    logic               capture, cap_vld, mul_vld;
    logic signed [7:0]  d;
    logic signed [16:0] prod;
    logic signed [15:0] p, wav_nxt;

    // A strobe landing on the capture cycle restarts the count, so it suppresses that capture.
    assign capture = (settle_cnt == 4'd1) && !bus.I_SMP_STB;

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state <= IDLE;
            gain  <= 8'd0;
        end else begin
            state <= state_nxt;
            gain  <= gain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gain_nxt  = gain;
        gain_dec  = (gain < FADE_STEP) ? 8'd0 : gain - FADE_STEP;
        case (state)
            IDLE: begin
                gain_nxt = 8'd0;
                if (bus.I_ACTIVE) begin
                    state_nxt = PLAY;
                    gain_nxt  = 8'd255;
                end
            end
            PLAY: begin
                gain_nxt = 8'd255;
                if (!bus.I_ACTIVE) state_nxt = FADE;
            end
            FADE: begin
                if (bus.I_ACTIVE) begin
                    state_nxt = PLAY;
                    gain_nxt  = 8'd255;
                end else if (bus.I_SMP_STB) begin
                    gain_nxt = gain_dec;
                    if (gain_dec == 8'd0) state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                gain_nxt  = 8'd0;
            end
        endcase
    end

    always_comb begin
        bus.O_BUSY = (state != IDLE);
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            settle_cnt <= 4'd0;
        end else if (bus.I_SMP_STB) begin
            settle_cnt <= 4'(SETTLE);
        end else if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    assign prod = 17'(d) * 17'($signed({1'b0, gain_cap}));

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            d             <= 8'sd0;
            gain_cap      <= 8'd0;
            cap_vld       <= 1'b0;
            p             <= 16'sd0;
            mul_vld       <= 1'b0;
            bus.O_WAV     <= 16'sd0;
            bus.O_SMP_VLD <= 1'b0;
        end else begin
            cap_vld       <= capture;
            mul_vld       <= cap_vld;
            bus.O_SMP_VLD <= mul_vld;
            if (capture) begin
                d        <= $signed(bus.I_ROM_DB - 8'h80);
                gain_cap <= gain;
            end
            if (cap_vld) p <= prod[15:0];
            if (mul_vld) bus.O_WAV <= wav_nxt;
        end
    end

`ifdef DKONG_WAV_LPF_EN
    logic signed [17:0] acc, acc_nxt;
    logic signed [18:0] diff;

    // 19-bit difference: target and accumulator can sit at opposite full-scale extremes.
    always_comb begin
        diff    = {p[15], p, 2'b00} - {acc[17], acc};
        acc_nxt = acc + 18'(diff >>> LPF_SHIFT);
        wav_nxt = acc_nxt[17:2];
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            acc <= 18'sd0;
        end else if (mul_vld) begin
            acc <= acc_nxt;
        end
    end
`else
    always_comb begin
        wav_nxt = p;
    end
`endif
endmodule
